sc_spi_target: RTL
==================

Name: sc_spi_target

Overview:
SPI target (slave) protocol engine. It is the responder-side counterpart of sc_spi_engine and is used as an on-chip SPI target port and as a loopback partner for the engine in system benches.
- CSB, SCLK and MOSI arrive from an external initiator and are oversampled in the SYSCLK domain.
- MISO is shifted out from a one-entry TX holding buffer.
- Each completed frame is presented as a parallel RXDATA word with a one-cycle valid pulse.

Parameters:
SYNC_STAGES, 2, synchronizer flops on CSB/SCLK/MOSI (legal 2..3).

Ports:
SYSCLK  in  1  system clock
SYSRSTB  in  1  asynchronous active-low reset
CPOL  in  1  clock idle level
CPHA  in  1  0: sample on leading edge; 1: sample on trailing edge
BORDER  in  1  0: MSB first; 1: LSB first
DWIDTH  in  5  frame length minus 1 (1..32 bits)
TXDATA  in  32  next transmit word
TXVALID  in  1  TXDATA valid
TXREADY  out  1  holding buffer empty
RXDATA  out  32  last received frame, right-aligned, upper bits zero
RXVALID  out  1  one-cycle pulse, RXDATA updated
TXUNDERRUN  out  1  one-cycle pulse, frame started with no TX word
ABORT  out  1  one-cycle pulse, CSB deasserted mid-frame
SPIBUSY  out  1  target selected (state ACTIVE)
CSB  in  1  chip select, active low
SCLK  in  1  SPI clock
MOSI  in  1  initiator data
MISO  out  1  target data
MISO_OE  out  1  MISO output enable (= SPIBUSY)

Behaviour:
Clocking and reset:
- Single clock SYSCLK. Reset is asynchronous and active-low on SYSRSTB.
- Reset values: all outputs 0, except TXREADY=1. Holding buffer empty, state IDLE.

Input conditioning:
- CSB, SCLK and MOSI each pass through SYNC_STAGES flops.
- Edges are detected against a one-cycle-delayed copy of the synchronized signal.
- Lead edge: SCLK_s goes from CPOL to !CPOL. Trail edge: the reverse.
- Sample edge = CPHA ? trail : lead. Shift edge = the other edge.
- SCLK frequency must be ≤ SYSCLK/8.

TX holding buffer:
- TXVALID&TXREADY writes TXDATA into the buffer; TXREADY then drops.
- The buffer is consumed on each frame load.
- Write and consume in the same cycle: the consume happens first, the new word is stored, TXREADY stays 0.

Configuration:
- CPOL, CPHA, BORDER and DWIDTH are captured at CSB_s fall.
- Changes while ACTIVE are ignored.

State machine (IDLE, ACTIVE):
- IDLE→ACTIVE on CSB_s falling. bitcnt=0.
- On entry, CPHA=0: load immediately. CPHA=1: set need_load.
- Load: shift register ← buffer if full, else 0 with a TXUNDERRUN pulse.
- Load ordering: MSB-first presents bit DWIDTH first; LSB-first presents bit 0 first.
- Shift edge: if need_load, load and clear need_load; else advance to the next bit.
- MISO updates in the same cycle as the edge detect, i.e. SYNC_STAGES+1 SYSCLK after the pin edge.
- Sample edge: capture MOSI_s into the RX shifter.
  - MSB-first: first bit lands at bit DWIDTH.
  - LSB-first: first bit lands at bit 0.
  - bitcnt increments.
- Frame complete (sample with bitcnt==DWIDTH): RXDATA ← received word, RXVALID pulses next cycle, bitcnt=0, need_load=1. Back-to-back frames under one CSB are supported.
- ACTIVE→IDLE on CSB_s rising.
  - If bitcnt≠0: partial bits are discarded, ABORT pulses, no RXVALID.
  - If bitcnt==0: no pulse.
  - Holding buffer contents are preserved unless already consumed.
- In IDLE: MISO=0, MISO_OE=0. SCLK edges are ignored.
- CSB rise and sample edge in the same cycle: the sample is dropped and CSB handling takes priority.
- Reset mid-frame: immediate return to reset values. No pulses are generated.

Optional Feature:
SC_SPI_TARGET_GLITCH_FILTER_EN
- Defined: a 3-sample majority filter follows the synchronizers on CSB and SCLK. A single-cycle glitch produces no edge. Latency grows by 2 SYSCLK and the SCLK limit becomes SYSCLK/10.
- Undefined: no filter, latency as stated above.

Test Plan:
1. Mode 0, BORDER=0, DWIDTH=7, TXDATA=0xA5 preloaded, initiator sends 0x3C → MISO bits 1,0,1,0,0,1,0,1; RXDATA=0x0000003C; one RXVALID; TXREADY returns to 1.
2. Mode 3, BORDER=1, DWIDTH=31, TXDATA=0x12345678, initiator sends 0xDEADBEEF → MISO LSB first 0,0,0,1,1,1,1,0…; RXDATA=0xDEADBEEF.
3. Mode 1, DWIDTH=7, two frames under one CSB, only first TX word written (0x5A) → second frame MISO all 0, TXUNDERRUN pulses once at second load, two RXVALID pulses.
4. Mode 2, DWIDTH=15, CSB rises after 5 SCLK → ABORT one pulse, no RXVALID, RXDATA unchanged, SPIBUSY=0 within SYNC_STAGES+1 cycles.
5. SYSRSTB asserted mid-frame at bit 3 → all outputs at reset values asynchronously. A new full frame after release (0x81) is received correctly.
6. With SC_SPI_TARGET_GLITCH_FILTER_EN: 1-cycle SCLK pulse inside a frame → bitcnt unchanged, final RXDATA matches the sent word.

Source files
------------

// File: rtl/sc_spi_target.sv
// SPI target engine: oversampled CSB/SCLK/MOSI, one-entry TX holding buffer, parallel RX word.
// Optional SC_SPI_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter on CSB and SCLK.
module sc_spi_target #(
    parameter int SYNC_STAGES = 2    // legal 2..3
) (
    input  logic        SYSCLK,
    input  logic        SYSRSTB,
    input  logic        CPOL,
    input  logic        CPHA,
    input  logic        BORDER,
    input  logic [4:0]  DWIDTH,
    input  logic [31:0] TXDATA,
    input  logic        TXVALID,
    output logic        TXREADY,
    output logic [31:0] RXDATA,
    output logic        RXVALID,
    output logic        TXUNDERRUN,
    output logic        ABORT,
    output logic        SPIBUSY,
    input  logic        CSB,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_OE
);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    // Packed as {mosi, sclk, csb}; CSB resets high so no false select edge after reset.
    logic [2:0] sync_reg [SYNC_STAGES];

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
                    if (!SYSRSTB) sync_reg[gi] <= 3'b001;
                    else          sync_reg[gi] <= {MOSI, SCLK, CSB};
                end
            end else begin : g_next
                always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
                    if (!SYSRSTB) sync_reg[gi] <= 3'b001;
                    else          sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    logic csb_s, sclk_s, mosi_s;

`ifdef SC_SPI_TARGET_GLITCH_FILTER_EN
    logic [2:0] csb_hist_reg, sclk_hist_reg;
    logic [1:0] mosi_dly_reg;

    always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            csb_hist_reg  <= 3'b111;
            sclk_hist_reg <= 3'b000;
            mosi_dly_reg  <= 2'b00;
        end else begin
            csb_hist_reg  <= {csb_hist_reg[1:0],  sync_reg[SYNC_STAGES-1][0]};
            sclk_hist_reg <= {sclk_hist_reg[1:0], sync_reg[SYNC_STAGES-1][1]};
            mosi_dly_reg  <= {mosi_dly_reg[0],    sync_reg[SYNC_STAGES-1][2]};
        end
    end

    // MOSI is delayed by the same two cycles so data stays aligned with the filtered SCLK.
    assign csb_s  = (csb_hist_reg[0] & csb_hist_reg[1]) | (csb_hist_reg[0] & csb_hist_reg[2]) |
                    (csb_hist_reg[1] & csb_hist_reg[2]);
    assign sclk_s = (sclk_hist_reg[0] & sclk_hist_reg[1]) | (sclk_hist_reg[0] & sclk_hist_reg[2]) |
                    (sclk_hist_reg[1] & sclk_hist_reg[2]);
    assign mosi_s = mosi_dly_reg[1];
`else
    assign csb_s  = sync_reg[SYNC_STAGES-1][0];
    assign sclk_s = sync_reg[SYNC_STAGES-1][1];
    assign mosi_s = sync_reg[SYNC_STAGES-1][2];
`endif

    state_t      state_reg, state_next;
    logic        csb_d_reg, sclk_d_reg;
    logic        cpol_reg, cpol_next, cpha_reg, cpha_next, border_reg, border_next;
    logic [4:0]  dwidth_reg, dwidth_next;
    logic [4:0]  bitcnt_reg, bitcnt_next;
    logic        need_load_reg, need_load_next;
    logic [31:0] tx_sr_reg, tx_sr_next;
    logic [31:0] rx_sr_reg, rx_sr_next;
    logic [31:0] tx_buf_reg, tx_buf_next;
    logic        tx_full_reg, tx_full_next;
    logic [31:0] rxdata_reg, rxdata_next;
    logic        rxvalid_reg, rxvalid_next;
    logic        underrun_reg, underrun_next;
    logic        abort_reg, abort_next;

    logic        csb_fall, csb_rise, sclk_lead, sclk_trail, sample_edge, shift_edge;
    logic        do_load, consume;
    logic [4:0]  rx_pos;
    logic [31:0] rx_word;

    assign csb_fall    = csb_d_reg & ~csb_s;
    assign csb_rise    = ~csb_d_reg & csb_s;
    assign sclk_lead   = (sclk_d_reg == cpol_reg) && (sclk_s != cpol_reg);
    assign sclk_trail  = (sclk_d_reg != cpol_reg) && (sclk_s == cpol_reg);
    assign sample_edge = cpha_reg ? sclk_trail : sclk_lead;
    assign shift_edge  = cpha_reg ? sclk_lead : sclk_trail;

    always_comb begin
        state_next     = state_reg;
        cpol_next      = cpol_reg;
        cpha_next      = cpha_reg;
        border_next    = border_reg;
        dwidth_next    = dwidth_reg;
        bitcnt_next    = bitcnt_reg;
        need_load_next = need_load_reg;
        tx_sr_next     = tx_sr_reg;
        rx_sr_next     = rx_sr_reg;
        tx_buf_next    = tx_buf_reg;
        rxdata_next    = rxdata_reg;
        rxvalid_next   = 1'b0;
        underrun_next  = 1'b0;
        abort_next     = 1'b0;
        do_load        = 1'b0;
        consume        = 1'b0;
        rx_pos         = border_reg ? bitcnt_reg : (dwidth_reg - bitcnt_reg);
        rx_word        = rx_sr_reg;
        rx_word[rx_pos] = mosi_s;

        case (state_reg)
            ST_IDLE: begin
                if (csb_fall) begin
                    state_next     = ST_ACTIVE;
                    cpol_next      = CPOL;
                    cpha_next      = CPHA;
                    border_next    = BORDER;
                    dwidth_next    = DWIDTH;
                    bitcnt_next    = 5'd0;
                    rx_sr_next     = 32'd0;
                    need_load_next = CPHA;
                    do_load        = ~CPHA;
                end
            end
            default: begin
                if (csb_rise) begin
                    // CSB release wins over any SCLK edge seen in the same cycle.
                    state_next     = ST_IDLE;
                    abort_next     = (bitcnt_reg != 5'd0);
                    bitcnt_next    = 5'd0;
                    need_load_next = 1'b0;
                end else begin
                    if (shift_edge) begin
                        if (need_load_reg) begin
                            do_load        = 1'b1;
                            need_load_next = 1'b0;
                        end else begin
                            tx_sr_next = border_reg ? (tx_sr_reg >> 1) : (tx_sr_reg << 1);
                        end
                    end
                    if (sample_edge) begin
                        if (bitcnt_reg == dwidth_reg) begin
                            rxdata_next    = rx_word;
                            rxvalid_next   = 1'b1;
                            bitcnt_next    = 5'd0;
                            need_load_next = 1'b1;
                            rx_sr_next     = 32'd0;
                        end else begin
                            rx_sr_next  = rx_word;
                            bitcnt_next = bitcnt_reg + 5'd1;
                        end
                    end
                end
            end
        endcase

        if (do_load) begin
            if (tx_full_reg) begin
                tx_sr_next = tx_buf_reg;
                consume    = 1'b1;
            end else begin
                tx_sr_next    = 32'd0;
                underrun_next = 1'b1;
            end
        end

        // Consume happens before a same-cycle write, so a fresh word stays held.
        tx_full_next = tx_full_reg & ~consume;
        if (TXVALID && !tx_full_reg) begin
            tx_buf_next  = TXDATA;
            tx_full_next = 1'b1;
        end
    end

    always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            state_reg     <= ST_IDLE;
            csb_d_reg     <= 1'b1;
            sclk_d_reg    <= 1'b0;
            cpol_reg      <= 1'b0;
            cpha_reg      <= 1'b0;
            border_reg    <= 1'b0;
            dwidth_reg    <= 5'd0;
            bitcnt_reg    <= 5'd0;
            need_load_reg <= 1'b0;
            tx_sr_reg     <= 32'd0;
            rx_sr_reg     <= 32'd0;
            tx_buf_reg    <= 32'd0;
            tx_full_reg   <= 1'b0;
            rxdata_reg    <= 32'd0;
            rxvalid_reg   <= 1'b0;
            underrun_reg  <= 1'b0;
            abort_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            csb_d_reg     <= csb_s;
            sclk_d_reg    <= sclk_s;
            cpol_reg      <= cpol_next;
            cpha_reg      <= cpha_next;
            border_reg    <= border_next;
            dwidth_reg    <= dwidth_next;
            bitcnt_reg    <= bitcnt_next;
            need_load_reg <= need_load_next;
            tx_sr_reg     <= tx_sr_next;
            rx_sr_reg     <= rx_sr_next;
            tx_buf_reg    <= tx_buf_next;
            tx_full_reg   <= tx_full_next;
            rxdata_reg    <= rxdata_next;
            rxvalid_reg   <= rxvalid_next;
            underrun_reg  <= underrun_next;
            abort_reg     <= abort_next;
        end
    end

    assign TXREADY    = ~tx_full_reg;
    assign RXDATA     = rxdata_reg;
    assign RXVALID    = rxvalid_reg;
    assign TXUNDERRUN = underrun_reg;
    assign ABORT      = abort_reg;
    assign SPIBUSY    = (state_reg == ST_ACTIVE);
    assign MISO_OE    = SPIBUSY;
    assign MISO       = SPIBUSY ? (border_reg ? tx_sr_reg[0] : tx_sr_reg[dwidth_reg]) : 1'b0;

endmodule
